// File: rtl/mul_issue_ctrl_pkg.sv
// Shared RV32 definitions for the multiplier issue/writeback sequencer.
// Holds the register-index type, x0 constant, tracking-tag struct and hazard helper.
package mul_issue_ctrl_pkg;

    localparam int unsigned MULT_STAGES_DEFAULT = 2;
    localparam int unsigned REG_IDX_W           = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t X0_IDX = '0;

    typedef struct packed {
        logic     v;
        reg_idx_t rd;
    } tag_t;

    // x0 is hardwired to zero, so a pending write to it never blocks a reader.
    function automatic logic src_hit(tag_t t, reg_idx_t rs, logic use_rs);
        return use_rs && t.v && (t.rd != X0_IDX) && (t.rd == rs);
    endfunction

endpackage

// File: rtl/mul_issue_ctrl_if.sv
// Issue/writeback bundle between decode and the multiplier sequencer.
// Decode side is master; the sequencer is slave. Status counters ride along.
interface mul_issue_ctrl_if
    import mul_issue_ctrl_pkg::*;
#(
    parameter int unsigned MULT_STAGES = MULT_STAGES_DEFAULT,
    parameter int unsigned CNT_W       = 32
);
    localparam int unsigned INFL_W = $clog2(MULT_STAGES + 1);

    logic              issue_valid;
    logic              issue_is_mul;
    reg_idx_t          issue_rd;
    reg_idx_t          issue_rs1;
    reg_idx_t          issue_rs2;
    logic              issue_use_rs1;
    logic              issue_use_rs2;
    logic              hold;
    logic              flush;

    logic              mul_valid;
    logic              issue_stall;
    logic              wb_valid;
    reg_idx_t          wb_rd;
    logic              busy;
    logic [INFL_W-1:0] inflight_cnt;
    logic [CNT_W-1:0]  mul_issued_cnt;
    logic [CNT_W-1:0]  stall_cycle_cnt;

    modport master (
        output issue_valid, issue_is_mul, issue_rd, issue_rs1, issue_rs2,
               issue_use_rs1, issue_use_rs2, hold, flush,
        input  mul_valid, issue_stall, wb_valid, wb_rd, busy, inflight_cnt,
               mul_issued_cnt, stall_cycle_cnt
    );

    modport slave (
        input  issue_valid, issue_is_mul, issue_rd, issue_rs1, issue_rs2,
               issue_use_rs1, issue_use_rs2, hold, flush,
        output mul_valid, issue_stall, wb_valid, wb_rd, busy, inflight_cnt,
               mul_issued_cnt, stall_cycle_cnt
    );

endinterface

// File: rtl/mul_issue_ctrl_tag_pipe.sv
// Shift register of {v, rd} tags mirroring the multiplier stages; index 0 is entry 1.
// One stage per un-held edge; flush clears all but the writeback entry.
module mul_tag_pipe
    import mul_issue_ctrl_pkg::*;
#(
    parameter int unsigned STAGES = MULT_STAGES_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold_i,
    input  logic              flush_i,
    input  tag_t              tag_i,
    output tag_t [STAGES-1:0] tags_o
);

    tag_t [STAGES-1:0] tags_q;
    tag_t [STAGES-1:0] tags_d;

    // The writeback entry takes its predecessor's pre-flush value, so an older
    // result still retires; under hold it simply keeps its own value.
    always_comb begin
        tags_d = tags_q;
        if (!hold_i) begin
            tags_d[0] = tag_i;
            for (int k = 1; k < STAGES; k++) begin
                tags_d[k] = tags_q[k-1];
            end
        end
        if (flush_i) begin
            for (int k = 0; k < STAGES - 1; k++) begin
                tags_d[k] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tags_q <= '0;
        end else begin
            tags_q <= tags_d;
        end
    end

    assign tags_o = tags_q;

endmodule

// File: rtl/mul_issue_ctrl.sv
// Multiplier issue/writeback sequencer: RAW stall, writeback tagging, perf counters.
// wb_valid follows an accepted MUL by MULT_STAGES un-held cycles; issue_stall is combinational.
module mul_issue_ctrl
    import mul_issue_ctrl_pkg::*;
#(
    parameter int unsigned MULT_STAGES = MULT_STAGES_DEFAULT,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    mul_issue_ctrl_if.slave        bus
);

    localparam int unsigned INFL_W = $clog2(MULT_STAGES + 1);

    tag_t [MULT_STAGES-1:0] tags;
    tag_t                   tag_in;
    logic                   hazard;
    logic                   stall;
    logic                   accept;
    logic                   mul_accept;
    logic [INFL_W-1:0]      infl;
    logic [CNT_W-1:0]       issued_q;
    logic [CNT_W-1:0]       issued_d;
    logic [CNT_W-1:0]       stalls_q;
    logic [CNT_W-1:0]       stalls_d;

    // The writeback entry is skipped: its value reaches the consumer by forwarding.
    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < MULT_STAGES - 1; k++) begin
            hazard = hazard
                   | src_hit(tags[k], bus.issue_rs1, bus.issue_use_rs1)
                   | src_hit(tags[k], bus.issue_rs2, bus.issue_use_rs2);
        end
    end

    assign stall      = bus.issue_valid & hazard;
    assign accept     = bus.issue_valid & ~stall & ~bus.hold & ~bus.flush;
    assign mul_accept = accept & bus.issue_is_mul;
    assign tag_in     = '{v: mul_accept, rd: bus.issue_rd};

    mul_tag_pipe #(
        .STAGES (MULT_STAGES)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .hold_i  (bus.hold),
        .flush_i (bus.flush),
        .tag_i   (tag_in),
        .tags_o  (tags)
    );

    always_comb begin
        infl = '0;
        for (int k = 0; k < MULT_STAGES; k++) begin
            infl = infl + INFL_W'(tags[k].v);
        end
    end

    always_comb begin
        issued_d = issued_q;
        stalls_d = stalls_q;
        if (!bus.hold) begin
            if (mul_accept) issued_d = issued_q + CNT_W'(1);
            if (stall)      stalls_d = stalls_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issued_q <= '0;
            stalls_q <= '0;
        end else begin
            issued_q <= issued_d;
            stalls_q <= stalls_d;
        end
    end

    assign bus.mul_valid       = mul_accept;
    assign bus.issue_stall     = stall;
    assign bus.wb_valid        = tags[MULT_STAGES-1].v & (tags[MULT_STAGES-1].rd != X0_IDX);
    assign bus.wb_rd           = tags[MULT_STAGES-1].rd;
    assign bus.busy            = (infl != '0);
    assign bus.inflight_cnt    = infl;
    assign bus.mul_issued_cnt  = issued_q;
    assign bus.stall_cycle_cnt = stalls_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl with a writeback scoreboard (MULT_STAGES=2).
module tb_mul_issue_ctrl;
    import mul_issue_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;

    int checks = 0;
    int errors = 0;
    int exp_issued = 0;
    int exp_stall  = 0;
    logic [4:0] sbq[$];

    mul_issue_ctrl_if #(.MULT_STAGES(2), .CNT_W(32)) bus ();

    mul_issue_ctrl #(.MULT_STAGES(2), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic m, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2);
        bus.issue_valid   = v;
        bus.issue_is_mul  = m;
        bus.issue_rd      = rd;
        bus.issue_rs1     = rs1;
        bus.issue_rs2     = rs2;
        bus.issue_use_rs1 = u1;
        bus.issue_use_rs2 = u2;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    // Retirement happens on an un-held writeback cycle; pop and compare there.
    task automatic settle();
        @(negedge clk);
        if (bus.wb_valid && !bus.hold) begin
            chk("sb_pending", 32'(sbq.size() != 0), 32'd1);
            if (sbq.size() != 0) chk("sb_wb_rd", 32'(bus.wb_rd), 32'(sbq.pop_front()));
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnts(input string tag);
        chk({tag, "_issued"}, bus.mul_issued_cnt, 32'(exp_issued));
        chk({tag, "_stalls"}, bus.stall_cycle_cnt, 32'(exp_stall));
    endtask

    initial begin
        rst = 1'b1;
        bus.hold  = 1'b0;
        bus.flush = 1'b0;
        idle();
        #12;
        chk("rst_mul_valid", 32'(bus.mul_valid), 32'd0);
        chk("rst_stall", 32'(bus.issue_stall), 32'd0);
        chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_inflight", 32'(bus.inflight_cnt), 32'd0);
        chk_cnts("rst");
        @(negedge clk);
        rst = 1'b0;
        adv();

        // single MUL rd=5
        drive(1'b1, 1'b1, 5'd5, 5'd1, 5'd2, 1'b1, 1'b1);
        sbq.push_back(5'd5); exp_issued++;
        settle();
        chk("t1_c0_mul_valid", 32'(bus.mul_valid), 32'd1);
        chk("t1_c0_stall", 32'(bus.issue_stall), 32'd0);
        chk("t1_c0_wb_valid", 32'(bus.wb_valid), 32'd0);
        adv();
        idle();
        settle();
        chk("t1_c1_busy", 32'(bus.busy), 32'd1);
        chk("t1_c1_inflight", 32'(bus.inflight_cnt), 32'd1);
        chk("t1_c1_wb_valid", 32'(bus.wb_valid), 32'd0);
        adv();
        settle();
        chk("t1_c2_wb_valid", 32'(bus.wb_valid), 32'd1);
        chk("t1_c2_wb_rd", 32'(bus.wb_rd), 32'd5);
        adv();
        settle();
        chk("t1_c3_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("t1_c3_busy", 32'(bus.busy), 32'd0);
        chk_cnts("t1");
        adv();

        // RAW: MUL rd=7 then ADD rs1=7
        drive(1'b1, 1'b1, 5'd7, 5'd1, 5'd2, 1'b1, 1'b1);
        sbq.push_back(5'd7); exp_issued++;
        settle();
        chk("t2_c0_mul_valid", 32'(bus.mul_valid), 32'd1);
        adv();
        drive(1'b1, 1'b0, 5'd8, 5'd7, 5'd3, 1'b1, 1'b1);
        settle();
        chk("t2_c1_stall", 32'(bus.issue_stall), 32'd1);
        chk("t2_c1_mul_valid", 32'(bus.mul_valid), 32'd0);
        exp_stall++;
        adv();
        settle();
        chk("t2_c2_stall", 32'(bus.issue_stall), 32'd0);
        chk("t2_c2_wb_valid", 32'(bus.wb_valid), 32'd1);
        chk_cnts("t2_c2");
        adv();
        idle();
        settle();
        chk("t2_c3_busy", 32'(bus.busy), 32'd0);
        chk_cnts("t2_c3");
        adv();

        // MUL to x0, consumer of x0
        drive(1'b1, 1'b1, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1);
        exp_issued++;
        settle();
        chk("t3_c0_mul_valid", 32'(bus.mul_valid), 32'd1);
        adv();
        drive(1'b1, 1'b0, 5'd6, 5'd4, 5'd0, 1'b1, 1'b1);
        settle();
        chk("t3_c1_stall", 32'(bus.issue_stall), 32'd0);
        chk("t3_c1_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("t3_c1_inflight", 32'(bus.inflight_cnt), 32'd1);
        adv();
        idle();
        settle();
        chk("t3_c2_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("t3_c2_busy", 32'(bus.busy), 32'd1);
        adv();
        settle();
        chk("t3_c3_busy", 32'(bus.busy), 32'd0);
        adv();

        // hold in cycles 1-3
        drive(1'b1, 1'b1, 5'd9, 5'd1, 5'd2, 1'b1, 1'b1);
        sbq.push_back(5'd9); exp_issued++;
        settle();
        adv();
        idle();
        bus.hold = 1'b1;
        settle();
        chk("t4_c1_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("t4_c1_inflight", 32'(bus.inflight_cnt), 32'd1);
        adv();
        drive(1'b1, 1'b0, 5'd10, 5'd9, 5'd0, 1'b1, 1'b0);
        settle();
        chk("t4_c2_stall", 32'(bus.issue_stall), 32'd1);
        chk("t4_c2_mul_valid", 32'(bus.mul_valid), 32'd0);
        adv();
        idle();
        settle();
        chk("t4_c3_inflight", 32'(bus.inflight_cnt), 32'd1);
        chk_cnts("t4_c3");
        adv();
        bus.hold = 1'b0;
        settle();
        chk("t4_c4_wb_valid", 32'(bus.wb_valid), 32'd0);
        adv();
        settle();
        chk("t4_c5_wb_valid", 32'(bus.wb_valid), 32'd1);
        chk("t4_c5_wb_rd", 32'(bus.wb_rd), 32'd9);
        adv();
        settle();
        chk("t4_c6_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk_cnts("t4_c6");
        adv();

        // back-to-back MULs with flush in cycle 1
        drive(1'b1, 1'b1, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1);
        sbq.push_back(5'd3); exp_issued++;
        settle();
        adv();
        drive(1'b1, 1'b1, 5'd4, 5'd1, 5'd2, 1'b1, 1'b1);
        bus.flush = 1'b1;
        settle();
        chk("t5_c1_mul_valid", 32'(bus.mul_valid), 32'd0);
        chk("t5_c1_stall", 32'(bus.issue_stall), 32'd0);
        adv();
        bus.flush = 1'b0;
        idle();
        settle();
        chk("t5_c2_wb_valid", 32'(bus.wb_valid), 32'd1);
        chk("t5_c2_wb_rd", 32'(bus.wb_rd), 32'd3);
        chk("t5_c2_inflight", 32'(bus.inflight_cnt), 32'd1);
        adv();
        settle();
        chk("t5_c3_inflight", 32'(bus.inflight_cnt), 32'd0);
        chk("t5_c3_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk_cnts("t5_c3");
        adv();

        // flush together with hold: writeback entry holds, younger entry dies
        drive(1'b1, 1'b1, 5'd11, 5'd1, 5'd2, 1'b1, 1'b1);
        sbq.push_back(5'd11); exp_issued++;
        settle();
        adv();
        drive(1'b1, 1'b1, 5'd12, 5'd1, 5'd2, 1'b1, 1'b1);
        sbq.push_back(5'd12); exp_issued++;
        settle();
        chk("t6_c1_mul_valid", 32'(bus.mul_valid), 32'd1);
        adv();
        idle();
        bus.hold  = 1'b1;
        bus.flush = 1'b1;
        settle();
        chk("t6_c2_wb_valid", 32'(bus.wb_valid), 32'd1);
        chk("t6_c2_wb_rd", 32'(bus.wb_rd), 32'd11);
        chk("t6_c2_inflight", 32'(bus.inflight_cnt), 32'd2);
        void'(sbq.pop_back());
        adv();
        bus.hold  = 1'b0;
        bus.flush = 1'b0;
        settle();
        chk("t6_c3_wb_valid", 32'(bus.wb_valid), 32'd1);
        chk("t6_c3_inflight", 32'(bus.inflight_cnt), 32'd1);
        adv();
        settle();
        chk("t6_c4_inflight", 32'(bus.inflight_cnt), 32'd0);
        chk("t6_c4_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk_cnts("t6_c4");
        adv();

        // asynchronous reset with two entries valid
        drive(1'b1, 1'b1, 5'd13, 5'd1, 5'd2, 1'b1, 1'b1);
        exp_issued++;
        settle();
        adv();
        drive(1'b1, 1'b1, 5'd14, 5'd1, 5'd2, 1'b1, 1'b1);
        exp_issued++;
        settle();
        adv();
        idle();
        #1;
        chk("t7_pre_inflight", 32'(bus.inflight_cnt), 32'd2);
        chk_cnts("t7_pre");
        rst = 1'b1;
        #1;
        chk("t7_busy", 32'(bus.busy), 32'd0);
        chk("t7_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("t7_inflight", 32'(bus.inflight_cnt), 32'd0);
        exp_issued = 0;
        exp_stall  = 0;
        chk_cnts("t7_rst");
        @(negedge clk);
        rst = 1'b0;
        adv();
        settle();
        chk("t7_post_busy", 32'(bus.busy), 32'd0);
        chk("t7_post_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk_cnts("t7_post");
        adv();

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
